// File: rtl/ieeedrv_pkg.sv
// Shared definitions for the IEEE drive SD arbiter.
//   sd_state_e : arbiter FSM states
//   sd_cmd_t   : command latched from the winning requester at grant time
//   LBA_W / BLK_CNT_W / GRANT_W : SD port field widths
package ieeedrv_pkg;
    localparam int LBA_W     = 32;
    localparam int BLK_CNT_W = 6;
    localparam int GRANT_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_DONE
    } sd_state_e;

    typedef struct packed {
        logic [LBA_W-1:0]     lba;
        logic [BLK_CNT_W-1:0] blk_cnt;
        logic                 wr;
    } sd_cmd_t;
endpackage

// File: rtl/ieeedrv_rrsel.sv
// Combinational round-robin winner select.
//   pending : per-requester request vector
//   last    : index of the previously granted requester
//   winner  : first pending requester searching from last+1 (mod SUBDRV)
//   valid   : at least one requester pending
module ieeedrv_rrsel
    import ieeedrv_pkg::*;
#(
    parameter int SUBDRV = 2
) (
    input  logic [SUBDRV-1:0]  pending,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] winner,
    output logic               valid
);
    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // The last-granted requester is visited last, so it is lowest priority.
        for (int k = 1; k <= SUBDRV; k++) begin
            idx = (int'(last) + k) % SUBDRV;
            if (!valid && pending[idx]) begin
                winner = GRANT_W'(idx);
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ieeedrv_sdarb.sv
// Arbiter sharing one SD block port between SUBDRV sub-drive requesters.
//   clk_sys, reset_n              : clock, async active-low reset
//   req_lba/req_blk_cnt/req_rd/req_wr/req_buff_din : per-requester command + write data
//   req_ack/req_done/req_err/busy : per-requester handshake/status, only granted lane active
//   sd_lba/sd_blk_cnt/sd_rd/sd_wr/sd_ack/sd_buff_din : shared SD port
//   grant                         : index of current/last granted requester
module ieeedrv_sdarb
    import ieeedrv_pkg::*;
#(
    parameter int          SUBDRV  = 2,
    parameter int unsigned TIMEOUT = 24'd8_000_000
) (
    input  logic                                clk_sys,
    input  logic                                reset_n,
    input  logic [SUBDRV-1:0][LBA_W-1:0]        req_lba,
    input  logic [SUBDRV-1:0][BLK_CNT_W-1:0]    req_blk_cnt,
    input  logic [SUBDRV-1:0]                   req_rd,
    input  logic [SUBDRV-1:0]                   req_wr,
    input  logic [SUBDRV-1:0][7:0]              req_buff_din,
    output logic [SUBDRV-1:0]                   req_ack,
    output logic [SUBDRV-1:0]                   req_done,
    output logic [SUBDRV-1:0]                   req_err,
    output logic [SUBDRV-1:0]                   busy,
    output logic [LBA_W-1:0]                    sd_lba,
    output logic [BLK_CNT_W-1:0]                sd_blk_cnt,
    output logic                                sd_rd,
    output logic                                sd_wr,
    input  logic                                sd_ack,
    output logic [7:0]                          sd_buff_din,
    output logic [GRANT_W-1:0]                  grant
);
    localparam int CW = $clog2(TIMEOUT + 1);

    sd_state_e          state, state_nxt;
    sd_cmd_t            cmd, cmd_win;
    logic [GRANT_W-1:0] grant_q, win;
    logic               win_vld;
    logic [CW-1:0]      tcnt;
    logic [SUBDRV-1:0]  err_q;
    logic               g_pend;
    logic               tmo;
    logic               abort;

    ieeedrv_rrsel #(.SUBDRV(SUBDRV)) u_rrsel (
        .pending (req_rd | req_wr),
        .last    (grant_q),
        .winner  (win),
        .valid   (win_vld)
    );

    // Lane muxes written as loops so a 2-bit grant never indexes past SUBDRV.
    always_comb begin
        cmd_win     = '0;
        g_pend      = 1'b0;
        sd_buff_din = '0;
        for (int i = 0; i < SUBDRV; i++) begin
            if (win == GRANT_W'(i))
                cmd_win = '{lba: req_lba[i], blk_cnt: req_blk_cnt[i], wr: req_wr[i]};
            if (grant_q == GRANT_W'(i)) begin
                g_pend      = req_rd[i] | req_wr[i];
                sd_buff_din = req_buff_din[i];
            end
        end
    end

    // Abort on the edge that ends the TIMEOUT-th ISSUE cycle.
    assign tmo   = (tcnt + CW'(1)) == CW'(TIMEOUT);
    assign abort = (state == ST_ISSUE) && !sd_ack && g_pend && tmo;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (win_vld) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (sd_ack)       state_nxt = ST_XFER;
                else if (!g_pend) state_nxt = ST_IDLE;
                else if (tmo)     state_nxt = ST_IDLE;
            end
            ST_XFER:  if (!sd_ack) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            cmd     <= '0;
            tcnt    <= '0;
            err_q   <= '0;
        end else begin
            state <= state_nxt;
            for (int i = 0; i < SUBDRV; i++)
                err_q[i] <= abort && (grant_q == GRANT_W'(i));
            if (state == ST_IDLE && win_vld) begin
                grant_q <= win;
                cmd     <= cmd_win;
                tcnt    <= '0;
            end else if (state == ST_ISSUE && !tmo) begin
                tcnt <= tcnt + CW'(1);
            end
        end
    end

    // Strobes decode straight from state so reset drops them asynchronously.
    assign sd_rd      = (state == ST_ISSUE) && !cmd.wr;
    assign sd_wr      = (state == ST_ISSUE) &&  cmd.wr;
    assign sd_lba     = cmd.lba;
    assign sd_blk_cnt = cmd.blk_cnt;
    assign grant      = grant_q;
    assign req_err    = err_q;

    always_comb begin
        req_ack  = '0;
        req_done = '0;
        busy     = '0;
        for (int i = 0; i < SUBDRV; i++) begin
            req_ack[i]  = sd_ack && (grant_q == GRANT_W'(i));
            req_done[i] = (state == ST_DONE) && (grant_q == GRANT_W'(i));
            busy[i]     = (state != ST_IDLE) && (grant_q == GRANT_W'(i));
        end
    end
endmodule

// File: tb/tb_ieeedrv_sdarb.sv
module tb_ieeedrv_sdarb;
    localparam int          N   = 2;
    localparam int unsigned TMO = 100;

    logic                clk_sys = 1'b0;
    logic                reset_n = 1'b0;
    logic [N-1:0][31:0]  req_lba;
    logic [N-1:0][5:0]   req_blk_cnt;
    logic [N-1:0]        req_rd, req_wr;
    logic [N-1:0][7:0]   req_buff_din;
    logic [N-1:0]        req_ack, req_done, req_err, busy;
    logic [31:0]         sd_lba;
    logic [5:0]          sd_blk_cnt;
    logic                sd_rd, sd_wr, sd_ack;
    logic [7:0]          sd_buff_din;
    logic [1:0]          grant;

    ieeedrv_sdarb #(.SUBDRV(N), .TIMEOUT(TMO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .req_lba(req_lba), .req_blk_cnt(req_blk_cnt),
        .req_rd(req_rd), .req_wr(req_wr), .req_buff_din(req_buff_din),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .busy(busy),
        .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_din(sd_buff_din), .grant(grant)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding command, who owns it, and
    // whether it has been acknowledged / is finishing.
    bit           m_active, m_acked, m_fin, m_wr;
    int           m_who, m_last, m_wait;
    logic [31:0]  m_lba;
    logic [5:0]   m_cnt;
    logic [N-1:0] m_err;

    always @(posedge clk_sys) begin
        m_err = '0;
        if (!reset_n) begin
            m_active = 0; m_acked = 0; m_fin = 0; m_wr = 0;
            m_who = 0; m_last = 0; m_wait = 0; m_lba = '0; m_cnt = '0;
        end else if (m_fin) begin
            m_active = 0;
            m_fin    = 0;
        end else if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                if (!m_active && (req_rd[(m_last + k) % N] || req_wr[(m_last + k) % N])) begin
                    m_active = 1;
                    m_acked  = 0;
                    m_wait   = 0;
                    m_who    = (m_last + k) % N;
                    m_last   = m_who;
                    m_wr     = req_wr[m_who];
                    m_lba    = req_lba[m_who];
                    m_cnt    = req_blk_cnt[m_who];
                end
            end
        end else if (!m_acked) begin
            if (sd_ack) m_acked = 1;
            else if (!(req_rd[m_who] || req_wr[m_who])) m_active = 0;
            else begin
                m_wait++;
                if (m_wait == int'(TMO)) begin
                    m_active     = 0;
                    m_err[m_who] = 1'b1;
                end
            end
        end else if (!sd_ack) begin
            m_fin = 1;
        end
    end

    logic [N-1:0] e_busy, e_done, e_ack;
    logic [7:0]   e_din;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            e_busy = '0; e_done = '0; e_ack = '0;
            if (m_active) e_busy[m_who] = 1'b1;
            if (m_fin)    e_done[m_who] = 1'b1;
            e_ack[m_last] = sd_ack;
            e_din = req_buff_din[m_last];
            chk("m_sd_rd",    sd_rd,       m_active && !m_acked && !m_wr);
            chk("m_sd_wr",    sd_wr,       m_active && !m_acked &&  m_wr);
            chk("m_sd_lba",   sd_lba,      m_lba);
            chk("m_sd_blk",   sd_blk_cnt,  m_cnt);
            chk("m_grant",    grant,       2'(m_last));
            chk("m_busy",     busy,        e_busy);
            chk("m_done",     req_done,    e_done);
            chk("m_err",      req_err,     m_err);
            chk("m_ack",      req_ack,     e_ack);
            chk("m_buff_din", sd_buff_din, e_din);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        req_lba = '0; req_blk_cnt = '0; req_rd = '0; req_wr = '0; sd_ack = 1'b0;
        req_buff_din[0] = 8'hA0; req_buff_din[1] = 8'h5B;
        repeat (3) tick();
        chk("rst_sd_rd", sd_rd, 1'b0);
        chk("rst_grant", grant, 2'd0);
        chk("rst_lba",   sd_lba, 32'd0);
        chk("rst_busy",  busy, 2'b00);
        reset_n = 1'b1;

        // Single read, long transfer, input changes after grant ignored
        req_rd[0] = 1'b1; req_lba[0] = 32'd357; req_blk_cnt[0] = 6'd0;
        tick();
        chk("a_sd_rd",  sd_rd, 1'b1);
        chk("a_lba",    sd_lba, 32'd357);
        chk("a_grant",  grant, 2'd0);
        sd_ack = 1'b1;
        tick();
        req_lba[0] = 32'd999; req_blk_cnt[0] = 6'd9;
        repeat (255) tick();
        chk("a_lba_hold", sd_lba, 32'd357);
        sd_ack = 1'b0;
        tick();
        chk("a_done", req_done, 2'b01);
        req_rd[0] = 1'b0;
        tick();
        chk("a_done_clr", req_done, 2'b00);
        chk("a_busy_clr", busy, 2'b00);

        // Simultaneous requests after reset: 1 then 0
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        req_lba[0] = 32'd100; req_blk_cnt[0] = 6'd3;
        req_lba[1] = 32'd200; req_blk_cnt[1] = 6'd7;
        req_buff_din[1] = 8'hC3;
        req_rd[0] = 1'b1; req_wr[1] = 1'b1;
        tick();
        chk("b_grant1", grant, 2'd1);
        chk("b_sd_wr",  sd_wr, 1'b1);
        chk("b_lba1",   sd_lba, 32'd200);
        chk("b_blk1",   sd_blk_cnt, 6'd7);
        chk("b_din1",   sd_buff_din, 8'hC3);
        sd_ack = 1'b1; tick();
        sd_ack = 1'b0; tick();
        chk("b_done1", req_done, 2'b10);
        req_wr[1] = 1'b0;
        tick(); tick();
        chk("b_grant0", grant, 2'd0);
        chk("b_sd_rd",  sd_rd, 1'b1);
        chk("b_lba0",   sd_lba, 32'd100);
        sd_ack = 1'b1; tick();
        sd_ack = 1'b0; tick();
        chk("b_done0", req_done, 2'b01);
        req_rd[0] = 1'b0;
        tick();

        // Read+write together: write wins; withdraw in ISSUE
        req_rd[1] = 1'b1; req_wr[1] = 1'b1;
        tick();
        chk("c_grant", grant, 2'd1);
        chk("c_sd_wr", sd_wr, 1'b1);
        chk("c_sd_rd", sd_rd, 1'b0);
        req_rd[1] = 1'b0; req_wr[1] = 1'b0;
        tick();
        chk("c_busy",  busy, 2'b00);
        chk("c_sd_wr0", sd_wr, 1'b0);
        chk("c_err",   req_err, 2'b00);
        chk("c_done",  req_done, 2'b00);
        tick();

        // Withdraw during XFER still completes
        req_rd[0] = 1'b1;
        tick();
        chk("d_grant", grant, 2'd0);
        sd_ack = 1'b1; tick();
        req_rd[0] = 1'b0; tick();
        chk("d_busy", busy, 2'b01);
        sd_ack = 1'b0; tick();
        chk("d_done", req_done, 2'b01);
        tick();

        // Timeout abort, then other pending requester granted
        req_rd[0] = 1'b1; req_rd[1] = 1'b1;
        tick();
        chk("e_grant1", grant, 2'd1);
        repeat (99) tick();
        chk("e_rd_c100", sd_rd, 1'b1);
        tick();
        chk("e_rd_c101", sd_rd, 1'b0);
        chk("e_err",     req_err, 2'b10);
        req_rd[1] = 1'b0;
        tick();
        chk("e_grant0", grant, 2'd0);
        chk("e_sd_rd0", sd_rd, 1'b1);
        chk("e_err_clr", req_err, 2'b00);

        // Reset during XFER
        sd_ack = 1'b1; tick();
        #2 reset_n = 1'b0;
        #1;
        chk("f_sd_rd", sd_rd, 1'b0);
        chk("f_busy",  busy, 2'b00);
        chk("f_grant", grant, 2'd0);
        chk("f_lba",   sd_lba, 32'd0);
        chk("f_blk",   sd_blk_cnt, 6'd0);
        chk("f_done",  req_done, 2'b00);
        req_rd = '0; sd_ack = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        repeat (4) begin
            tick();
            chk("f_post_done", req_done, 2'b00);
            chk("f_post_err",  req_err, 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
